counter_capture: RTL and testbench

- Snapshot bank that stores the 8-bit counter output `out` into a 16 x 8 register bank.
- Mirrors the existing load path in the other direction: today the counter loads from the register file; this block writes the counter's value back into a register bank.
- Sits beside TOP. Its `value` input is tied to the counter output, and the bench or controller reads the stored samples through an addressed read port.

---
 rtl/counter_capture.sv | 71 +++++++
 tb/tb_counter_capture.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_capture.sv
// counter_capture: 16-deep snapshot bank for counter samples with a registered read port.
// Defining COUNTER_CAPTURE_DELTA_EN also captures automatically whenever value changes.
module counter_capture #(
    parameter int DATA_W = 8,
    parameter int ADR_W  = 4
) (
    input  logic              clk,
    input  logic              rst_async_n,
    input  logic              clr,
    input  logic [DATA_W-1:0] value,
    input  logic              capture,
    input  logic              wrap,
    input  logic              rd_en,
    input  logic [ADR_W-1:0]  rd_adr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADR_W-1:0]  wr_ptr,
    output logic [ADR_W:0]    count,
    output logic              full,
    output logic              overflow
);
    localparam logic [ADR_W:0] FULL_CNT = {1'b1, {ADR_W{1'b0}}};

    logic [DATA_W-1:0] mem [2**ADR_W];
    logic take;
    logic accept;
    logic drop;

`ifdef COUNTER_CAPTURE_DELTA_EN
    logic [DATA_W-1:0] prev_value;

    always_ff @(posedge clk or negedge rst_async_n)
        if (!rst_async_n) prev_value <= '0;
        else prev_value <= value;

    assign take = capture | (value != prev_value);
`else
    assign take = capture;
`endif

    assign full   = count == FULL_CNT;
    assign accept = take & ~clr & (~full | wrap);
    assign drop   = take & ~clr & full & ~wrap;

    // read samples mem before this edge's write lands, giving read-before-write
    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            mem      <= '{default: '0};
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= mem[rd_adr];
            if (clr) begin
                wr_ptr   <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else begin
                if (accept) begin
                    mem[wr_ptr] <= value;
                    wr_ptr      <= wr_ptr + 1'b1;
                    if (!full) count <= count + 1'b1;
                end
                if (drop) overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_counter_capture.sv
// tb_counter_capture: directed scoreboard bench for counter_capture.
// Mirrors COUNTER_CAPTURE_DELTA_EN so the same sequence covers both builds.
module tb_counter_capture;
    logic       clk = 1'b0;
    logic       rst_async_n = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] value = '0;
    logic       capture = 1'b0;
    logic       wrap = 1'b0;
    logic       rd_en = 1'b0;
    logic [3:0] rd_adr = '0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [3:0] wr_ptr;
    logic [4:0] count;
    logic       full;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    logic [7:0] m_mem [16];
    logic [3:0] m_ptr;
    int         m_cnt;
    logic       m_ovf;
    logic [7:0] m_rd;
    logic [7:0] m_prev;
    logic [7:0] cur_v;
    logic [7:0] rd_q [$];

    counter_capture dut (
        .clk(clk), .rst_async_n(rst_async_n), .clr(clr), .value(value),
        .capture(capture), .wrap(wrap), .rd_en(rd_en), .rd_adr(rd_adr),
        .rd_data(rd_data), .rd_valid(rd_valid), .wr_ptr(wr_ptr),
        .count(count), .full(full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        m_ptr = '0;
        m_cnt = 0;
        m_ovf = 1'b0;
        m_rd = '0;
        m_prev = '0;
        rd_q.delete();
    endtask

    task automatic check_status();
        chk("wr_ptr", wr_ptr, m_ptr);
        chk("count", count, m_cnt);
        chk("full", full, m_cnt == 16);
        chk("overflow", overflow, m_ovf);
    endtask

    task automatic step(input logic c, input logic [7:0] v, input logic w,
                        input logic r, input logic [3:0] a, input logic cl);
        logic take;
        capture = c; value = v; wrap = w; rd_en = r; rd_adr = a; clr = cl;
        take = c;
`ifdef COUNTER_CAPTURE_DELTA_EN
        take = c | (v != m_prev);
        m_prev = v;
`endif
        if (r) rd_q.push_back(m_mem[a]);
        if (cl) begin
            m_ptr = '0; m_cnt = 0; m_ovf = 1'b0;
        end else if (take && (m_cnt != 16 || w)) begin
            m_mem[m_ptr] = v;
            m_ptr = m_ptr + 1'b1;
            if (m_cnt != 16) m_cnt++;
        end else if (take) begin
            m_ovf = 1'b1;
        end
        cur_v = v;
        @(posedge clk);
        #1;
        if (r) begin
            m_rd = rd_q.pop_front();
            chk("rd_data", rd_data, m_rd);
            chk("rd_valid", rd_valid, 1);
        end else begin
            chk("rd_valid_idle", rd_valid, 0);
            chk("rd_hold", rd_data, m_rd);
        end
        check_status();
    endtask

    task automatic cap(input logic [7:0] v, input logic w);
        step(1'b1, v, w, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic rd(input logic [3:0] a);
        step(1'b0, cur_v, 1'b0, 1'b1, a, 1'b0);
    endtask

    task automatic do_clr();
        step(1'b0, cur_v, 1'b0, 1'b0, 4'd0, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_wr_ptr"}, wr_ptr, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_overflow"}, overflow, 0);
    endtask

    initial begin
        model_reset();
        cur_v = '0;
        #2;
        check_all_zero("reset");
        #11;
        rst_async_n = 1'b1;
        @(posedge clk);
        #1;
        rd(4'd0); rd(4'd5); rd(4'd15);
        // basic captures and a delayed read
        cap(8'd5, 1'b0); cap(8'd6, 1'b0); cap(8'd7, 1'b0);
        chk("basic_count", count, 3);
        chk("basic_ptr", wr_ptr, 3);
        rd(4'd1);
        chk("basic_rd1", rd_data, 6);
        step(1'b0, cur_v, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("basic_rd_valid_drop", rd_valid, 0);
        // fill without wrap, then drop one
        do_clr();
        for (int i = 0; i < 16; i++) cap(8'(i), 1'b0);
        chk("fill_full", full, 1);
        cap(8'd99, 1'b0);
        chk("drop_overflow", overflow, 1);
        chk("drop_ptr", wr_ptr, 0);
        rd(4'd0);
        chk("drop_mem0", rd_data, 0);
        rd(4'd15);
        // fill with wrap, overwrite oldest
        do_clr();
        chk("clr_overflow", overflow, 0);
        for (int i = 0; i < 16; i++) cap(8'(i), 1'b1);
        cap(8'd99, 1'b1);
        chk("wrap_count", count, 16);
        chk("wrap_ptr", wr_ptr, 1);
        chk("wrap_overflow", overflow, 0);
        rd(4'd0);
        chk("wrap_mem0", rd_data, 99);
        // read-before-write on the same address
        do_clr();
        cap(8'd5, 1'b0); cap(8'd6, 1'b0); cap(8'd7, 1'b0);
        do_clr();
        cap(8'd5, 1'b0); cap(8'd6, 1'b0);
        step(1'b1, 8'd42, 1'b0, 1'b1, 4'd2, 1'b0);
        chk("rbw_old", rd_data, 7);
        rd(4'd2);
        chk("rbw_new", rd_data, 42);
        // clr wins over a simultaneous capture
        do_clr();
        for (int i = 0; i < 5; i++) cap(8'(20 + i), 1'b0);
        step(1'b1, 8'd8, 1'b0, 1'b1, 4'd4, 1'b1);
        chk("clrcap_count", count, 0);
        chk("clrcap_ptr", wr_ptr, 0);
        rd(4'd5);
        chk("clrcap_not_stored", rd_data == 8'd8, 0);
        rd(4'd0);
        chk("clrcap_mem0", rd_data, 20);
        // asynchronous reset between edges with a read in flight
        do_clr();
        for (int i = 0; i < 3; i++) cap(8'(30 + i), 1'b0);
        step(1'b1, 8'd33, 1'b0, 1'b1, 4'd1, 1'b0);
        chk("pre_rst_count", count, 4);
        #3;
        rst_async_n = 1'b0;
        capture = 1'b0; rd_en = 1'b0; clr = 1'b0; value = '0; wrap = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        cur_v = '0;
        #2;
        rst_async_n = 1'b1;
        @(posedge clk);
        #1;
        rd(4'd1);
`ifdef COUNTER_CAPTURE_DELTA_EN
        step(1'b0, 8'd3, 1'b0, 1'b0, 4'd0, 1'b0);
        step(1'b0, 8'd3, 1'b0, 1'b0, 4'd0, 1'b0);
        step(1'b0, 8'd4, 1'b0, 1'b0, 4'd0, 1'b0);
        step(1'b0, 8'd4, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("delta_count", count, 2);
        rd(4'd0);
        chk("delta_mem0", rd_data, 3);
        rd(4'd1);
        chk("delta_mem1", rd_data, 4);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
